// File: rtl/counter_decoder.sv
// counter_decoder: turns successive samples of a 7-bit DCO ripple counter into DCO edges
// per reference period, rejects skew-glitch jumps and accumulates a wrapping phase word.
// Latency: sample captured at edge n appears in delta/phase_acc/err at edge n+1; no backpressure.
module counter_decoder #(
  parameter int CNT_W      = 7,
  parameter int ACC_W      = 16,
  parameter int COUNT_DOWN = 1,
  parameter int DELTA_MAX  = 100,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_err,
  input  logic [CNT_W-1:0] count_in,
  output logic [CNT_W-1:0] delta,
  output logic             delta_valid,
  output logic [ACC_W-1:0] phase_acc,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] DMAX    = CNT_W'(DELTA_MAX);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Two warm-up states make sure samp and samp_d hold real counter samples
  // before the first difference is ever used.
  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    IDLE  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] samp;
  logic [CNT_W-1:0] samp_d;
  logic [CNT_W-1:0] last_good;
  logic [CNT_W-1:0] raw;
  logic [CNT_W-1:0] sel;
  logic             accept;
  logic             update;

  // Modular difference of the two latest samples; truncation to CNT_W bits
  // absorbs counter wrap-around in either count direction.
  always_comb begin
    raw    = (COUNT_DOWN != 0) ? (samp_d - samp) : (samp - samp_d);
    accept = (raw <= DMAX);
    sel    = accept ? raw : last_good;
    update = (state == RUN) && en;
  end

  // Next-state logic: fixed warm-up, then en toggles between IDLE and RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      WARM0:   state_nxt = WARM1;
      WARM1:   state_nxt = IDLE;
      IDLE:    state_nxt = en ? RUN : IDLE;
      RUN:     state_nxt = en ? RUN : IDLE;
      default: state_nxt = WARM0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WARM0;
    end else begin
      state <= state_nxt;
    end
  end

  // Sample pipeline keeps shifting in every state so the first difference
  // after a re-enable spans only a single reference period.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp   <= '0;
      samp_d <= '0;
    end else begin
      samp   <= count_in;
      samp_d <= samp;
    end
  end

  // Decoded delta and phase accumulation; a rejected difference is replaced
  // by the last accepted one (0 if nothing has been accepted yet).
  always_ff @(posedge clk) begin
    if (rst) begin
      delta       <= '0;
      last_good   <= '0;
      phase_acc   <= '0;
      delta_valid <= 1'b0;
      err         <= 1'b0;
    end else if (update) begin
      delta       <= sel;
      if (accept) begin
        last_good <= raw;
      end
      phase_acc   <= phase_acc + ACC_W'(sel);
      delta_valid <= 1'b1;
      err         <= ~accept;
    end else begin
      delta_valid <= 1'b0;
      err         <= 1'b0;
    end
  end

  // Saturating glitch counter; an explicit clear beats a coincident reject.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (update && !accept && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_counter_decoder.sv
// Bench for counter_decoder: a down-counting and an up-counting instance share stimulus
// and are checked every cycle against a cycle-level reference model plus directed checks.
module tb_counter_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr_err;
  logic [6:0] count_in;

  logic [6:0]  d0, d1;
  logic        dv0, dv1;
  logic [15:0] acc0, acc1;
  logic        e0, e1;
  logic [7:0]  ec0, ec1;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // reference model state, index 0 = down-counting instance, 1 = up-counting
  int m_s[2], m_sd[2], m_lg[2], m_d[2], m_acc[2], m_dv[2], m_e[2], m_ec[2];
  int m_warm;
  bit m_run;
  int drv[$];

  counter_decoder #(.CNT_W(7), .ACC_W(16), .COUNT_DOWN(1), .DELTA_MAX(100), .ERR_W(8)) dut_dn (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .count_in(count_in),
    .delta(d0), .delta_valid(dv0), .phase_acc(acc0), .err(e0), .err_cnt(ec0)
  );

  counter_decoder #(.CNT_W(7), .ACC_W(16), .COUNT_DOWN(0), .DELTA_MAX(100), .ERR_W(8)) dut_up (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .count_in(count_in),
    .delta(d1), .delta_valid(dv1), .phase_acc(acc1), .err(e1), .err_cnt(ec1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic int mod128(input int x);
    return ((x % 128) + 128) % 128;
  endfunction

  function automatic logic [32:0] obs(input int i);
    if (i == 0) return {d0, dv0, acc0, e0, ec0};
    return {d1, dv1, acc1, e1, ec1};
  endfunction

  function automatic logic [32:0] expv(input int i);
    return {7'(m_d[i]), 1'(m_dv[i]), 16'(m_acc[i]), 1'(m_e[i]), 8'(m_ec[i])};
  endfunction

  // One reference clock edge worth of behaviour, from the rules of the block.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int raw;
      bit rej;
      rej = 1'b0;
      if (rst) begin
        m_s[i] = 0; m_sd[i] = 0; m_lg[i] = 0; m_d[i] = 0;
        m_acc[i] = 0; m_dv[i] = 0; m_e[i] = 0; m_ec[i] = 0;
      end else begin
        if (m_run && en) begin
          raw = (i == 0) ? mod128(m_sd[i] - m_s[i]) : mod128(m_s[i] - m_sd[i]);
          if (raw <= 100) begin
            m_d[i] = raw; m_lg[i] = raw; m_e[i] = 0;
          end else begin
            m_d[i] = m_lg[i]; m_e[i] = 1; rej = 1'b1;
          end
          m_acc[i] = (m_acc[i] + m_d[i]) % 65536;
          m_dv[i] = 1;
        end else begin
          m_dv[i] = 0; m_e[i] = 0;
        end
        if (clr_err) m_ec[i] = 0;
        else if (rej && m_ec[i] < 255) m_ec[i] = m_ec[i] + 1;
        m_sd[i] = m_s[i];
        m_s[i]  = int'(count_in);
      end
    end
    if (rst) begin
      m_warm = 0; m_run = 1'b0;
    end else if (m_warm < 2) begin
      m_warm = m_warm + 1;
    end else begin
      m_run = en;
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit c, input int v);
    rst = r; en = e; clr_err = c; count_in = 7'(v);
    drv.push_back(mod128(v));
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs(i) !== 33'd0) begin
        miscompares++;
        $display("FAIL reset_zero inst%0d: got %h want 0", i, obs(i));
      end
    end
    drive(1, 1, 0, 55);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs(i) !== expv(i)) begin
        miscompares++;
        $display("FAIL reset_hold inst%0d: got %h want %h", i, obs(i), expv(i));
      end
    end
  endtask

  task automatic test_down_steady();
    int c;
    c = 127;
    for (int k = 0; k < 30; k++) begin
      drive(0, 1, 0, c);
      c = mod128(c - 10);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          miscompares++;
          $display("FAIL steady inst%0d cyc%0d: got %h want %h", i, cyc, obs(i), expv(i));
        end
      end
      if (k >= 3) begin
        vectors++;
        if (d0 !== 7'd10 || dv0 !== 1'b1 || e0 !== 1'b0) begin
          miscompares++;
          $display("FAIL steady_delta cyc%0d: got d=%0d v=%0d e=%0d want d=10 v=1 e=0", cyc, d0, dv0, e0);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int dn_seq[5];
    int up_seq[5];
    dn_seq = '{23, 13, 3, 121, 111};
    up_seq = '{105, 115, 125, 7, 17};
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, dn_seq[k]);
      vectors++;
      if (obs(0) !== expv(0)) begin
        miscompares++;
        $display("FAIL wrap_dn_model cyc%0d: got %h want %h", cyc, obs(0), expv(0));
      end
      if (k >= 2) begin
        vectors++;
        if (d0 !== 7'd10 || e0 !== 1'b0) begin
          miscompares++;
          $display("FAIL wrap_dn cyc%0d: got d=%0d e=%0d want d=10 e=0", cyc, d0, e0);
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, up_seq[k]);
      vectors++;
      if (obs(1) !== expv(1)) begin
        miscompares++;
        $display("FAIL wrap_up_model cyc%0d: got %h want %h", cyc, obs(1), expv(1));
      end
      if (k >= 2) begin
        vectors++;
        if (d1 !== 7'd10 || e1 !== 1'b0) begin
          miscompares++;
          $display("FAIL wrap_up cyc%0d: got d=%0d e=%0d want d=10 e=0", cyc, d1, e1);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int seq[12];
    int want_d[12];
    int want_e[12];
    seq    = '{90, 80, 70, 60, 50, 60, 50, 40, 68, 95, 85, 75};
    want_d = '{-1, -1, 10, 10, 10, 10, 10, 10, 10, 100, 100, 10};
    want_e = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, (k == 0), seq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          miscompares++;
          $display("FAIL glitch_model inst%0d cyc%0d: got %h want %h", i, cyc, obs(i), expv(i));
        end
      end
      vectors++;
      if (e0 !== 1'(want_e[k]) || (want_d[k] >= 0 && d0 !== 7'(want_d[k]))) begin
        miscompares++;
        $display("FAIL glitch step%0d: got d=%0d e=%0d want d=%0d e=%0d", k, d0, e0, want_d[k], want_e[k]);
      end
      if (k == 0 || k == 6 || k == 10) begin
        vectors++;
        if (ec0 !== ((k == 0) ? 8'd0 : (k == 6) ? 8'd1 : 8'd2)) begin
          miscompares++;
          $display("FAIL glitch_errcnt step%0d: got %0d", k, ec0);
        end
      end
    end
  endtask

  task automatic test_en_gating();
    int c;
    int held;
    c = drv[$];
    held = m_acc[0];
    for (int k = 0; k < 5; k++) begin
      c = mod128(c - 7);
      drive(0, 0, 0, c);
      vectors++;
      if (dv0 !== 1'b0 || acc0 !== 16'(held) || obs(1) !== expv(1)) begin
        miscompares++;
        $display("FAIL gate_hold cyc%0d: got v=%0d acc=%0d want v=0 acc=%0d", cyc, dv0, acc0, held);
      end
    end
    c = mod128(c - 3);
    drive(0, 1, 0, c);
    vectors++;
    if (dv0 !== 1'b0 || acc0 !== 16'(held)) begin
      miscompares++;
      $display("FAIL gate_reentry cyc%0d: got v=%0d acc=%0d want v=0 acc=%0d", cyc, dv0, acc0, held);
    end
    c = mod128(c - 3);
    drive(0, 1, 0, c);
    vectors++;
    if (dv0 !== 1'b1 || d0 !== 7'(mod128(drv[$-2] - drv[$-1])) || acc0 !== 16'((held + 3) % 65536)) begin
      miscompares++;
      $display("FAIL gate_first cyc%0d: got v=%0d d=%0d acc=%0d want v=1 d=3 acc=%0d", cyc, dv0, d0, acc0, (held + 3) % 65536);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs(i) !== expv(i)) begin
        miscompares++;
        $display("FAIL gate_model inst%0d cyc%0d: got %h want %h", i, cyc, obs(i), expv(i));
      end
    end
  endtask

  task automatic test_reset_midrun();
    int c;
    c = drv[$];
    drive(1, 1, 0, c);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs(i) !== 33'd0) begin
        miscompares++;
        $display("FAIL midrun_reset inst%0d: got %h want 0", i, obs(i));
      end
    end
    for (int k = 1; k <= 5; k++) begin
      c = mod128(c - 10);
      drive(0, 1, 0, c);
      vectors++;
      if (dv0 !== ((k >= 4) ? 1'b1 : 1'b0) || obs(0) !== expv(0)) begin
        miscompares++;
        $display("FAIL midrun_warm tick%0d: got v=%0d (%h) want v=%0d (%h)", k, dv0, obs(0), (k >= 4), expv(0));
      end
    end
  endtask

  task automatic test_acc_wrap();
    int c;
    c = 127;
    drive(1, 0, 0, 0);
    for (int k = 0; k < 3 + 6554; k++) begin
      drive(0, 1, 0, c);
      c = mod128(c - 10);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          miscompares++;
          $display("FAIL accwrap_model inst%0d cyc%0d: got %h want %h", i, cyc, obs(i), expv(i));
        end
      end
    end
    vectors++;
    if (acc0 !== 16'd4) begin
      miscompares++;
      $display("FAIL accwrap_final: got %0d want 4", acc0);
    end
    vectors++;
    if (ec1 !== 8'd255 || d1 !== 7'd0 || acc1 !== 16'd0) begin
      miscompares++;
      $display("FAIL errcnt_sat: got ec=%0d d=%0d acc=%0d want ec=255 d=0 acc=0", ec1, d1, acc1);
    end
    drive(0, 1, 1, c);
    vectors++;
    if (ec1 !== 8'd0 || e1 !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_on_reject: got ec=%0d e=%0d want ec=0 e=1", ec1, e1);
    end
  endtask

  task automatic test_random();
    int c;
    int step;
    bit r, e, cl;
    c = $urandom_range(0, 127);
    for (int k = 0; k < 3000; k++) begin
      step = $urandom_range(0, 100);
      if ($urandom_range(0, 15) == 0) c = $urandom_range(0, 127);
      else c = mod128(c - step);
      r  = ($urandom_range(0, 499) == 0);
      e  = ($urandom_range(0, 7) != 0);
      cl = ($urandom_range(0, 31) == 0);
      drive(r, e, cl, c);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== expv(i)) begin
          miscompares++;
          $display("FAIL random inst%0d cyc%0d: got %h want %h", i, cyc, obs(i), expv(i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; count_in = '0;
    m_warm = 0; m_run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_s[i] = 0; m_sd[i] = 0; m_lg[i] = 0; m_d[i] = 0;
      m_acc[i] = 0; m_dv[i] = 0; m_e[i] = 0; m_ec[i] = 0;
    end
    test_reset();
    test_down_steady();
    test_wrap();
    test_glitch();
    test_en_gating();
    test_reset_midrun();
    test_acc_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_decoder.md
Name: counter_decoder

Overview:
- Reference-clock-domain reader for the 7-bit skew-compensated DCO ripple counter.
- The counter's sampled word steps once per DCO rising edge, modulo 128; it counts down by default.
- Each clk cycle this block computes the modular difference between consecutive samples, giving the DCO edges per reference period.
- It rejects implausible differences caused by ripple/skew glitches and accumulates the result into a wrapping integer phase for the ADPLL phase detector.

Parameters:
- CNT_W, 7: counter sample width; modulus 2^CNT_W.
- ACC_W, 16: phase accumulator width.
- COUNT_DOWN, 1: 1 = sample decreases per DCO edge; 0 = sample increases.
- DELTA_MAX, 100: largest accepted per-cycle difference. Range 1..2^CNT_W-1.
- ERR_W, 8: width of the saturating glitch counter.

Ports:
- clk, input, 1: reference clock; the same clock that samples the counter.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: run enable.
- clr_err, input, 1: synchronous clear of err_cnt.
- count_in, input, CNT_W: sampled counter word.
- delta, output, CNT_W: decoded DCO edges in the last reference period.
- delta_valid, output, 1: delta and phase_acc updated this cycle.
- phase_acc, output, ACC_W: running sum of delta, modulo 2^ACC_W.
- err, output, 1: one-cycle pulse; the raw difference was rejected this cycle.
- err_cnt, output, ERR_W: saturating count of rejected differences.

Behaviour:
- Reset: rst sampled high at a posedge clears all of the following on that edge:
  - samp, samp_d, last_good, delta, phase_acc, err_cnt: 0.
  - delta_valid, err: 0.
  - FSM: WARM0.
- rst has priority over every other input and acts identically mid-run.
- Input pipeline, every cycle regardless of state: samp <= count_in, then samp_d <= samp.
- Raw difference, modulo 2^CNT_W:
  - COUNT_DOWN=1: raw = samp_d - samp.
  - COUNT_DOWN=0: raw = samp - samp_d.
  - Wrap-around is handled by truncating to CNT_W bits.
- FSM states: WARM0, WARM1, IDLE, RUN.
  - WARM0 -> WARM1 -> IDLE, unconditionally, one cycle each. This guarantees samp and samp_d hold real samples.
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0.
  - en is ignored in WARM0 and WARM1.
- Updates in RUN, registered on each edge while in RUN with en=1:
  - Accept: if raw <= DELTA_MAX, then delta <= raw, last_good <= raw, err <= 0.
  - Reject: otherwise delta <= last_good, err <= 1, and err_cnt increments. err_cnt saturates at 2^ERR_W-1.
  - phase_acc <= phase_acc + selected delta, truncated to ACC_W bits.
  - delta_valid <= 1.
- Zero-delta case: raw = 0 is valid (DCO stalled) and is accepted.
- A reject before any accept substitutes 0.
- Latency: a count_in value present before edge n contributes to delta, phase_acc and err registered at edge n+1. Each output is a function of the samples captured at edges n-1 and n.
- Outside RUN, and on the RUN->IDLE edge:
  - delta_valid = 0, err = 0.
  - delta, phase_acc and last_good hold their values.
  - samp and samp_d keep shifting.
- Re-enable: IDLE->RUN resumes accumulating from the held phase_acc. The first difference after re-enable spans only one reference period, because samp_d stays fresh.
- err_cnt and clr_err:
  - clr_err=1 clears err_cnt in any state.
  - If clr_err coincides with a reject, the clear wins: err_cnt = 0, and err still pulses.
- No combinational path from inputs to outputs.

Test Plan:
- Down-count steady: COUNT_DOWN=1, en=1 after warm-up, count_in = 127, 117, 107, ... each cycle -> delta=10 and delta_valid=1 every cycle; phase_acc increments by 10 per cycle; err stays 0.
- Counter wrap: consecutive samples 3 then 121 -> delta=10, no err. With COUNT_DOWN=0, samples 125 then 7 -> delta=10.
- Glitch rejection: last_good=10, samples 50 then 60 (raw=118 > 100) -> delta=10, err pulses for exactly 1 cycle, err_cnt 0 -> 1; the next clean step of 10 is accepted. Raw=100 is accepted; raw=101 is rejected.
- Accumulator wrap: constant delta=10 from phase_acc=0 for 6554 RUN cycles -> phase_acc=4 (65540 mod 65536).
- en gating: deassert en for 5 cycles mid-run -> delta_valid=0 and phase_acc held across the gap; after re-assert, the first delta equals the one-period difference of the two latest samples.
- Reset and counters: rst high mid-RUN -> next edge all outputs 0 and FSM in WARM0; no delta_valid until 2 warm-up cycles plus RUN entry have elapsed. Force 300 rejects with ERR_W=8 -> err_cnt=255. clr_err coinciding with a reject -> err_cnt=0.
